life_engine: RTL and testbench

LIFE_ENGINE -- requirements
Module: life_engine

---
 rtl/life_pkg.sv | 8 +
 rtl/life_nbr_count.sv | 26 ++
 rtl/life_engine.sv | 116 +++++++++++
 tb/tb_life_engine.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared state encoding and default geometry/rule parameters
package life_pkg;
    typedef enum logic [1:0] {IDLE, SNAP, CALC} state_t;
    localparam int W_BITS_DEF = 3;
    localparam int H_BITS_DEF = 3;
    localparam logic [8:0] BIRTH_DEF = 9'b000001000;
    localparam logic [8:0] SURVIVE_DEF = 9'b000001100;
endpackage

// File: rtl/life_nbr_count.sv
// life_nbr_count: combinational 8-neighbour live count, dead or toroidal edges
module life_nbr_count #(
    parameter int W_BITS = 3,
    parameter int H_BITS = 3
) (
    input  logic [2**(W_BITS+H_BITS)-1:0] prev_i,
    input  logic [W_BITS+H_BITS-1:0]      idx_i,
    input  logic                          wrap_i,
    output logic [3:0]                    cnt_o
);
    logic [H_BITS:0] rx;
    logic [W_BITS:0] cx;
    always_comb begin
        cnt_o = '0;
        rx = '0;
        cx = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rx = {1'b0, idx_i[W_BITS+H_BITS-1:W_BITS]} + (H_BITS+1)'(i) - (H_BITS+1)'(1);
                cx = {1'b0, idx_i[W_BITS-1:0]} + (W_BITS+1)'(j) - (W_BITS+1)'(1);
                if ((i != 1 || j != 1) && (wrap_i || !(rx[H_BITS] || cx[W_BITS])))
                    cnt_o = cnt_o + 4'(prev_i[{rx[H_BITS-1:0], cx[W_BITS-1:0]}]);
            end
        end
    end
endmodule

// File: rtl/life_engine.sv
// life_engine: cell-serial cellular automaton with snapshot board for a stable display
module life_engine
    import life_pkg::*;
#(
    parameter int W_BITS = W_BITS_DEF,
    parameter int H_BITS = H_BITS_DEF,
    parameter int WRAP = 0,
    parameter logic [8:0] BIRTH = BIRTH_DEF,
    parameter logic [8:0] SURVIVE = SURVIVE_DEF,
    parameter logic [2**(W_BITS+H_BITS)-1:0] INIT = '0,
    parameter int GEN_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step_i,
    input  logic                     load_valid_i,
    input  logic [W_BITS+H_BITS-1:0] load_addr_i,
    input  logic                     load_data_i,
    input  logic [W_BITS+H_BITS-1:0] rd_addr_i,
    output logic                     rd_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [GEN_W-1:0]         gen_count_o,
    output logic [W_BITS+H_BITS:0]   pop_count_o
);
    localparam int A = W_BITS + H_BITS;
    localparam int N = 2**A;

    function automatic logic [A:0] popcnt(input logic [N-1:0] v);
        popcnt = '0;
        for (int i = 0; i < N; i++) popcnt = popcnt + (A+1)'(v[i]);
    endfunction

    localparam logic [A:0] POP_INIT = popcnt(INIT);

    state_t state_q, state_d;
    logic [N-1:0] curr_q, curr_d, prev_q, prev_d;
    logic [A-1:0] idx_q, idx_d;
    logic [A:0] acc_q, acc_d, pop_q, pop_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic done_q, done_d;
    logic [3:0] cnt;
    logic new_cell;

    life_nbr_count #(.W_BITS(W_BITS), .H_BITS(H_BITS)) u_nbr (
        .prev_i(prev_q),
        .idx_i(idx_q),
        .wrap_i(1'(WRAP)),
        .cnt_o(cnt)
    );

    assign new_cell = prev_q[idx_q] ? SURVIVE[cnt] : BIRTH[cnt];

    always_comb begin
        state_d = state_q;
        curr_d = curr_q;
        prev_d = prev_q;
        idx_d = idx_q;
        acc_d = acc_q;
        pop_d = pop_q;
        gen_d = gen_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid_i) curr_d[load_addr_i] = load_data_i;
                if (step_i) state_d = SNAP;
            end
            SNAP: begin
                prev_d = curr_q;
                idx_d = '0;
                acc_d = '0;
                state_d = CALC;
            end
            CALC: begin
                curr_d[idx_q] = new_cell;
                acc_d = acc_q + (A+1)'(new_cell);
                idx_d = idx_q + A'(1);
                if (&idx_q) begin
                    state_d = IDLE;
                    gen_d = gen_q + GEN_W'(1);
                    pop_d = acc_d;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            curr_q <= INIT;
            prev_q <= INIT;
            idx_q <= '0;
            acc_q <= '0;
            pop_q <= POP_INIT;
            gen_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            curr_q <= curr_d;
            prev_q <= prev_d;
            idx_q <= idx_d;
            acc_q <= acc_d;
            pop_q <= pop_d;
            gen_q <= gen_d;
            done_q <= done_d;
        end
    end

    assign busy_o = state_q != IDLE;
    assign done_o = done_q;
    assign gen_count_o = gen_q;
    assign pop_count_o = pop_q;
    assign rd_data_o = busy_o ? prev_q[rd_addr_i] : curr_q[rd_addr_i];
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: scoreboard bench, dead-edge and toroidal engines against a Conway reference model
module tb_life_engine;
    localparam logic [63:0] INIT0 = 64'h0F00_3C00_1200_8181;
    localparam logic [63:0] INIT1 = 64'h0000_0000_0007_0402;

    typedef struct {
        bit [63:0] pre0, pre1, post0, post1;
        int pop0, pop1, gen;
        longint dcyc;
    } exp_t;

    logic clk = 1'b0, reset = 1'b0, step = 1'b0, load_valid = 1'b0, load_data = 1'b0;
    logic [5:0] load_addr = '0, rd_addr = '0;
    logic rd0, rd1, busy0, busy1, done0, done1;
    logic [15:0] gen0, gen1;
    logic [6:0] pop0, pop1;
    longint cyc = 0;
    int tests = 0, fails = 0, calc_cyc = 0;
    exp_t exp_q[$], idle_q[$];
    bit [63:0] b0, b1;
    int gen = 0;

    life_engine #(.WRAP(0), .INIT(INIT0)) u0 (
        .clk(clk), .reset(reset), .step_i(step), .load_valid_i(load_valid),
        .load_addr_i(load_addr), .load_data_i(load_data), .rd_addr_i(rd_addr),
        .rd_data_o(rd0), .busy_o(busy0), .done_o(done0), .gen_count_o(gen0), .pop_count_o(pop0)
    );
    life_engine #(.WRAP(1), .INIT(INIT1)) u1 (
        .clk(clk), .reset(reset), .step_i(step), .load_valid_i(load_valid),
        .load_addr_i(load_addr), .load_data_i(load_data), .rd_addr_i(rd_addr),
        .rd_data_o(rd1), .busy_o(busy1), .done_o(done1), .gen_count_o(gen1), .pop_count_o(pop1)
    );

    always #100 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit [63:0] life_next(bit [63:0] b, bit wrap);
        bit [63:0] n;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int live;
                live = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) continue;
                        live += int'(b[rr*8+cc]);
                    end
                end
                n[r*8+c] = b[r*8+c] ? (live == 2 || live == 3) : (live == 3);
            end
        end
        return n;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sweep(output bit [63:0] v0, output bit [63:0] v1);
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            #1;
            v0[i] = rd0;
            v1[i] = rd1;
        end
    endtask

    initial begin
        exp_t e;
        bit [63:0] v0, v1;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                calc_cyc = 0;
                continue;
            end
            if (done0 || done1) begin
                calc_cyc = 0;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done0=%0d done1=%0d with no generation pending", done0, done1);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_pair", {done0, done1}, 2'b11);
                    chk("done_cycle", cyc, e.dcyc);
                    chk("gen0", gen0, e.gen);
                    chk("gen1", gen1, e.gen);
                    chk("pop0", pop0, e.pop0);
                    chk("pop1", pop1, e.pop1);
                    sweep(v0, v1);
                    chk("board0", v0, e.post0);
                    chk("board1", v1, e.post1);
                end
            end else if (busy0 || busy1) begin
                calc_cyc++;
                if (calc_cyc == 12 && exp_q.size() > 0) begin
                    sweep(v0, v1);
                    chk("display0", v0, exp_q[0].pre0);
                    chk("display1", v1, exp_q[0].pre1);
                    chk("busy_pair", {busy0, busy1}, 2'b11);
                end
            end else begin
                calc_cyc = 0;
                if (idle_q.size() > 0) begin
                    e = idle_q.pop_front();
                    chk("idle_gen0", gen0, e.gen);
                    chk("idle_gen1", gen1, e.gen);
                    chk("idle_pop0", pop0, e.pop0);
                    chk("idle_pop1", pop1, e.pop1);
                    sweep(v0, v1);
                    chk("idle_board0", v0, e.post0);
                    chk("idle_board1", v1, e.post1);
                end
            end
        end
    end

    task automatic push_idle();
        exp_t e;
        e.pre0 = b0;
        e.pre1 = b1;
        e.post0 = b0;
        e.post1 = b1;
        e.pop0 = $countones(b0);
        e.pop1 = $countones(b1);
        e.gen = gen;
        e.dcyc = 0;
        idle_q.push_back(e);
        for (int i = 0; i < 20 && idle_q.size() > 0; i++) @(negedge clk);
        if (idle_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: %0d idle checks left, required 0", idle_q.size());
            idle_q.delete();
        end
    endtask

    task automatic load_cell(int a, bit d);
        @(negedge clk);
        load_valid = 1'b1;
        load_addr = 6'(a);
        load_data = d;
        b0[a] = d;
        b1[a] = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic set_board(bit [63:0] p);
        for (int i = 0; i < 64; i++) load_cell(i, p[i]);
    endtask

    task automatic do_step(bit with_load, bit junk);
        exp_t e;
        int a;
        @(negedge clk);
        if (with_load) begin
            a = $urandom_range(0, 63);
            load_valid = 1'b1;
            load_addr = 6'(a);
            load_data = 1'($urandom);
            b0[a] = load_data;
            b1[a] = load_data;
        end
        e.pre0 = b0;
        e.pre1 = b1;
        b0 = life_next(b0, 1'b0);
        b1 = life_next(b1, 1'b1);
        gen = (gen + 1) % 65536;
        e.post0 = b0;
        e.post1 = b1;
        e.pop0 = $countones(b0);
        e.pop1 = $countones(b1);
        e.gen = gen;
        e.dcyc = cyc + 66;
        exp_q.push_back(e);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        load_valid = 1'b0;
        if (junk) begin
            repeat (5) @(negedge clk);
            step = 1'b1;
            load_valid = 1'b1;
            load_addr = '0;
            load_data = ~b0[0];
            @(negedge clk);
            step = 1'b0;
            load_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: %0d generations pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        b0 = INIT0;
        b1 = INIT1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        push_idle();
        set_board(64'h0000_0000_0E00_0000);
        do_step(0, 0);
        wait_done();
        set_board(64'h0000_0000_0000_0103);
        do_step(0, 0);
        wait_done();
        set_board(INIT1);
        repeat (32) begin
            do_step(0, 0);
            wait_done();
        end
        set_board({32'($urandom), 32'($urandom)});
        do_step(0, 1);
        wait_done();
        push_idle();
        repeat (8) begin
            repeat ($urandom_range(0, 4)) load_cell($urandom_range(0, 63), 1'($urandom));
            do_step(1'($urandom), 1'($urandom));
            wait_done();
        end
        do_step(0, 0);
        repeat (21) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        b0 = INIT0;
        b1 = INIT1;
        gen = 0;
        @(negedge clk);
        reset = 1'b1;
        push_idle();
        do_step(0, 0);
        wait_done();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
